// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), restoring radix-2, one quotient bit per clock.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle on divide-by-zero or |dividend| < |divisor|.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic [4:0]      reg_waddr_o
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] END  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            op_rem_q, op_rem_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] result_d;
  logic            ready_d, busy_d;
  logic [4:0]      waddr_d;

  // Operand decode at issue: signed ops are DIV/REM (funct3 1x0)
  logic            is_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_signed = op_i[2] & ~op_i[0];
  assign a_neg     = is_signed & dividend_i[XLEN-1];
  assign b_neg     = is_signed & divisor_i[XLEN-1];
  assign a_mag     = a_neg ? XLEN'(0) - dividend_i : dividend_i;
  assign b_mag     = b_neg ? XLEN'(0) - divisor_i : divisor_i;
  assign b_zero    = (divisor_i == '0);

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], q_bit};

  // Sign correction; a zero divisor leaves |dividend| in rem, which restores the original dividend
  logic [XLEN-1:0] q_fix, r_fix, fin_res;

  assign q_fix   = dz_q ? {XLEN{1'b1}} : (neg_q_q ? XLEN'(0) - quo_nxt : quo_nxt);
  assign r_fix   = neg_r_q ? XLEN'(0) - rem_nxt : rem_nxt;
  assign fin_res = op_rem_q ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      op_rem_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_q        <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      reg_waddr_o <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      op_rem_q    <= op_rem_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      dz_q        <= dz_d;
      result_o    <= result_d;
      ready_o     <= ready_d;
      busy_o      <= busy_d;
      reg_waddr_o <= waddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_rem_d = op_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    waddr_d  = reg_waddr_o;
    result_d = '0;
    ready_d  = 1'b0;
    busy_d   = busy_o;

    case (state_q)
      IDLE: begin
        if (start_i && !ready_o) begin
          op_rem_d = op_i[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          dz_d     = b_zero;
          waddr_d  = reg_waddr_i;
          quo_d    = a_mag;
          dvs_d    = b_mag;
          rem_d    = '0;
          count_d  = '0;
          state_d  = CALC;
          busy_d   = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          if (b_zero || (a_mag < b_mag)) begin
            state_d  = END;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            result_d = op_i[1] ? dividend_i : (b_zero ? {XLEN{1'b1}} : '0);
          end
`endif
        end
      end
      CALC: begin
        if (!start_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d   = rem_nxt;
          quo_d   = quo_nxt;
          count_d = count_q + CW'(1);
          if (count_q == CW'(XLEN - 1)) begin
            state_d  = END;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            result_d = fin_res;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and random checks of ex_div through a result scoreboard.
module tb_ex_div;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  waddr;
    int          cyc;
    int          busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] result_o;
  logic        ready_o, busy_o;
  logic [4:0]  reg_waddr_o;

  int tests_run = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .reg_waddr_o(reg_waddr_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference RV32M divide semantics
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb_) : 32'(sa / sb_);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic bit early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? 32'd0 - a : a;
    mb = (!op[0] && b[31]) ? 32'd0 - b : b;
    return (b == 32'd0) || (ma < mb);
  endfunction

  // Issue one op with start held through the ready cycle, then compare against the scoreboard
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] w, input logic [31:0] exp_res, input string tag);
    exp_t e, got_e;
    bit eo;
    int n, busy_n;
    logic leak;
`ifdef DIV_EARLY_OUT_EN
    eo = early(op, a, b);
`else
    eo = 1'b0;
`endif
    e.res = exp_res;
    e.waddr = w;
    e.cyc = eo ? 1 : 33;
    e.busy = eo ? 0 : 32;
    sb.push_back(e);
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = w;
    n = 0; busy_n = 0; leak = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ready_o) break;
      if (busy_o) busy_n++;
      if (result_o !== 32'd0) leak = 1'b1;
    end
    got_e = sb.pop_front();
    if (ready_o) begin
      chk({tag, " result"}, result_o, got_e.res);
      chk({tag, " waddr"}, 32'(reg_waddr_o), 32'(got_e.waddr));
      chk({tag, " cycles"}, 32'(n), 32'(got_e.cyc));
      chk({tag, " busy"}, 32'(busy_n), 32'(got_e.busy));
      chk({tag, " quiet"}, 32'(leak), 32'd0);
      @(negedge clk);
      chk({tag, " single pulse"}, 32'(ready_o), 32'd0);
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, " no retrigger"}, 32'({ready_o, busy_o}), 32'd0);
    end else begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
      start_i = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    rst = 1'b1; start_i = 1'b0; op_i = 3'b101;
    dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {result_o[31:8], reg_waddr_o, busy_o, ready_o, 1'b0}, 32'd0);
    chk("reset result", result_o, 32'd0);
    rst = 1'b0;

    run_op(3'b101, 32'd100, 32'd7, 5'd5, 32'd14, "divu 100/7");
    run_op(3'b111, 32'd100, 32'd7, 5'd6, 32'd2, "remu 100/7");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, "div -7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, "rem -7/2");
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, "div 7/-2");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, "rem ovf");
    run_op(3'b101, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, "divu 5/0");
    run_op(3'b110, 32'd5, 32'd0, 5'd13, 32'd5, "rem 5/0");
    run_op(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFF, "div -5/0");
    run_op(3'b101, 32'd3, 32'd10, 5'd15, 32'd0, "divu 3/10");

    // Abort after ten CALC cycles
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd20;
    repeat (11) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("abort idle", 32'({busy_o, ready_o}), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) cnt++;
    end
    chk("abort no ready", 32'(cnt), 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 5'd21, 32'd3, "divu 9/3 after abort");

    // Reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd22;
    repeat (6) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("midrst flags", 32'({busy_o, ready_o, reg_waddr_o}), 32'd0);
    chk("midrst result", result_o, 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) cnt++;
    end
    chk("midrst quiet", 32'(cnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      rop = {1'b1, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rop[0] == 1'b0 && i == 5) rb = 32'hFFFF_FF00;
      run_op(rop, ra, rb, 5'(i + 1), model(rop, ra, rb), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle RV32M divide unit, downstream of the ID/EX pipeline register.
- The execute stage forwards DIV/DIVU/REM/REMU operands (rs1/rs2 read data plus destination register) and holds the pipeline while busy_o is high.
- The result is written back to the register file on the ready_o pulse.
- Restoring radix-2 algorithm on operand magnitudes, one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  request; held high by EX for the whole operation, low = abort
- op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- dividend_i  input  XLEN  rs1 data
- divisor_i  input  XLEN  rs2 data
- reg_waddr_i  input  5  destination register
- result_o  output  XLEN  quotient or remainder, valid while ready_o=1
- ready_o  output  1  one-cycle completion pulse
- busy_o  output  1  operation in progress, EX asserts pipeline hold
- reg_waddr_o  output  5  destination register captured at start

Behaviour:
- Reset: state=IDLE; result_o=0; ready_o=0; busy_o=0; reg_waddr_o=0; internal counter, quotient and remainder registers cleared. A reset in any state takes effect at the next edge and discards the operation; no ready_o is produced.
- States are IDLE, CALC and END.
- IDLE:
  - When start_i=1 and ready_o=0, latch op_i, reg_waddr_i, |dividend|, |divisor| and result-sign flags.
  - Set busy_o=1, count=0, remainder accumulator=0, then go to CALC. Call this edge E0.
  - For a signed op, the magnitude is the two's complement negate when the MSB is 1. 0x80000000 maps to unsigned 2^31.
- CALC: each edge shifts {rem,dividend} left by 1.
  - If rem ≥ divisor: rem -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - count increments on each edge. On the edge completing iteration XLEN (E32), go to END.
- END entry edge:
  - Compute the corrected result.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder takes the dividend's sign.
  - Load result_o, set ready_o=1 and busy_o=0.
- END: the next edge clears ready_o and result_o and returns to IDLE. A start_i still high in the ready cycle is ignored, so there is no re-trigger on the same instruction.
- Latency: start sampled at E0, ready_o high for the cycle after E32, i.e. 32 clocks.
- Divide by zero, no trap:
  - Quotient = all ones.
  - Remainder = original dividend.
  - Sign correction is bypassed.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives quotient 0x80000000 and REM gives 0. This falls out of the magnitude path with no special case.
- Abort: start_i=0 in CALC means the next edge returns to IDLE with busy_o=0 and no ready_o. This covers a branch/jump flush in EX.
- result_o is 0 whenever ready_o=0.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at E0, if divisor=0 or |dividend|<|divisor|, go directly to END. ready_o is then high in the cycle after E0 (latency 1).
  - Quotient is all ones for divide by zero, else 0.
  - Remainder is the original dividend.
- Undefined: all operations take the full 32 iterations. The divide-by-zero result is forced at END and is identical to the above.

Test Plan:
- DIVU 100/7 with start held → busy_o high 32 cycles; ready_o pulse with result_o=14, reg_waddr_o as captured; REMU gives 2.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Latency is 32 without DIV_EARLY_OUT_EN and 1 with it; DIVU 3/10 → 0 with latency 1 under the macro.
- Drop start_i after 10 CALC cycles → IDLE at next edge, busy_o=0, ready_o never asserted. A new DIVU 9/3 started immediately after → 3.
- Assert rst mid-CALC → all outputs 0 next cycle, no ready_o. start_i held through the ready cycle → exactly one ready_o pulse per start.
